// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit: instruction-fetch front end for the 5-stage core.
//   Generates the PC, issues in-order requests to instruction memory with a
//   credit scheme, buffers returned instructions with their PC in a FIFO and
//   hands them to ID through a valid/ready handshake. A redirect flushes the
//   buffer and discards every response that is still in flight.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     request channel (addr = current PC)
//   imem_rsp_valid/data           in-order responses, always accepted
//   redirect_valid/redirect_pc    redirect fetch to a new PC
//   inst_valid/ready/data/pc      FIFO head towards ID
// Also contains pipe_fetch_unit_chk, a port-level checker that watches the
// memory interface for responses without a matching outstanding request.

module pipe_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_W / 8);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] rsp_pc_r;
    logic [OUT_W-1:0]  outstanding_r;
    logic [OUT_W-1:0]  drop_r;
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [ADDR_W-1:0] pc_mem_r   [FIFO_DEPTH];
    logic [INST_W-1:0] data_mem_r [FIFO_DEPTH];

    logic [CNT_W:0]    credit_used_s;
    logic              empty_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [OUT_W-1:0]  outstanding_nxt_s;
    logic [OUT_W-1:0]  drop_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;

    // Buffered entries plus requests in flight never exceed the FIFO size,
    // so every response that is kept is guaranteed a free slot.
    assign credit_used_s  = (CNT_W + 1)'(count_r) + (CNT_W + 1)'(outstanding_r);
    assign imem_req_valid = reset_n && !redirect_valid && (credit_used_s < DEPTH_C);
    assign imem_req_addr  = pc_r;

    assign empty_s  = (count_r == {CNT_W{1'b0}});
    assign accept_s = imem_req_valid && imem_req_ready;
    assign push_s   = imem_rsp_valid && (drop_r == {OUT_W{1'b0}}) && !redirect_valid;
    assign pop_s    = !empty_s && inst_ready && !redirect_valid;

    assign inst_valid = !empty_s;
    assign inst_data  = empty_s ? {INST_W{1'b0}} : data_mem_r[rd_ptr_r];
    assign inst_pc    = empty_s ? {ADDR_W{1'b0}} : pc_mem_r[rd_ptr_r];

    // Next value of the in-flight request counter.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        case ({accept_s, imem_rsp_valid})
            2'b10:   outstanding_nxt_s = outstanding_r + OUT_W'(1);
            2'b01:   outstanding_nxt_s = outstanding_r - OUT_W'(1);
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Next value of the discard counter: on redirect every request still in
    // flight after this cycle becomes stale (no request issues on redirect).
    always_comb begin
        drop_nxt_s = drop_r;
        if (redirect_valid) begin
            drop_nxt_s = outstanding_r - (imem_rsp_valid ? OUT_W'(1) : OUT_W'(0));
        end else if (imem_rsp_valid && (drop_r != {OUT_W{1'b0}})) begin
            drop_nxt_s = drop_r - OUT_W'(1);
        end else begin
            drop_nxt_s = drop_r;
        end
    end

    // Next FIFO occupancy for a non-redirect cycle.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Fetch PC and the PC tagged onto the next kept response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r     <= RESET_PC;
            rsp_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r     <= redirect_pc;
            rsp_pc_r <= redirect_pc;
        end else begin
            if (accept_s) begin
                pc_r <= pc_r + PC_STEP;
            end
            if (push_s) begin
                rsp_pc_r <= rsp_pc_r + PC_STEP;
            end
        end
    end

    // In-flight and discard counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_r <= {OUT_W{1'b0}};
            drop_r        <= {OUT_W{1'b0}};
        end else begin
            outstanding_r <= outstanding_nxt_s;
            drop_r        <= drop_nxt_s;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer outright.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // FIFO storage: instruction and its PC written together on push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_r[i]   <= {ADDR_W{1'b0}};
                data_mem_r[i] <= {INST_W{1'b0}};
            end
        end else if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
            data_mem_r[wr_ptr_r] <= imem_rsp_data;
        end
    end

endmodule

// pipe_fetch_unit_chk: watches the memory channel of a pipe_fetch_unit and
// flags a response arriving with no request outstanding, or more requests in
// flight than the fetch buffer can absorb.
// Ports: clk, reset_n, imem_req_valid, imem_req_ready, imem_rsp_valid (inputs).
module pipe_fetch_unit_chk #(
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic reset_n,
    input logic imem_req_valid,
    input logic imem_req_ready,
    input logic imem_rsp_valid
);

    localparam int OUT_W = $clog2(FIFO_DEPTH + 1) + 1;

    logic [OUT_W-1:0] inflight_r;

    // Independent count of requests accepted but not yet answered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r <= {OUT_W{1'b0}};
        end else begin
            inflight_r <= inflight_r
                          + ((imem_req_valid && imem_req_ready) ? OUT_W'(1) : OUT_W'(0))
                          - (imem_rsp_valid ? OUT_W'(1) : OUT_W'(0));
        end
    end

    rsp_has_request: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rsp_valid |-> (inflight_r != {OUT_W{1'b0}}));

    inflight_bounded: assert property (@(posedge clk) disable iff (!reset_n)
        inflight_r <= OUT_W'(FIFO_DEPTH));

endmodule
